// File: rtl/decoder_scan.sv
// Registered one-hot channel decoder with direct select and masked
// round-robin scan; every output has one cycle of latency.
module decoder_scan #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Enable,
  input  logic                  Mode,
  input  logic [SEL_W-1:0]      S,
  input  logic                  Load,
  input  logic [2**SEL_W-1:0]   Mask,
  output logic [2**SEL_W-1:0]   O,
  output logic [SEL_W-1:0]      Idx,
  output logic                  Valid,
  output logic                  Wrap
);

  localparam int N    = 2 ** SEL_W;
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [N-1:0]      o_q, o_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic [SEL_W-1:0]  nxt;
  logic [SEL_W-1:0]  cand;

  // Nearest eligible index after idx_q, circularly; offset N is idx_q itself.
  always_comb begin
    nxt  = idx_q;
    cand = idx_q;
    for (int k = N; k >= 1; k--) begin
      cand = idx_q + SEL_W'(k);
      if (Mask[cand]) nxt = cand;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    o_d     = '0;
    wrap_d  = 1'b0;
    if (!Enable) begin
      state_d = ST_OFF;
    end else if (!Mode) begin
      state_d    = ST_DIRECT;
      idx_d      = S;
      dwell_d    = '0;
      o_d[S]     = 1'b1;
    end else begin
      state_d = ST_SCAN;
      if (Load) begin
        idx_d   = S;
        dwell_d = '0;
      end else if (state_q != ST_SCAN) begin
        dwell_d = '0;
      end else if (Mask == '0) begin
        dwell_d = dwell_q;
      end else if (dwell_q == DW_LAST) begin
        idx_d   = nxt;
        dwell_d = '0;
        wrap_d  = (nxt <= idx_q);
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
      o_d[idx_d] = Mask[idx_d];
    end
    valid_d = |o_d;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_OFF;
      idx_q   <= '0;
      dwell_q <= '0;
      o_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign O     = o_q;
  assign Idx   = idx_q;
  assign Valid = valid_q;
  assign Wrap  = wrap_q;

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 The block SHALL have parameter SEL_W, default 3: select width; output width is 2**SEL_W.
REQ-002 The block SHALL have parameter DWELL, default 4: cycles each channel is held in scan mode; legal range 1..256.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port Clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-005 Port Rst_n, input, 1: synchronous active-low reset.
REQ-006 Port Enable, input, 1: 1 = block active; 0 = outputs forced off.
REQ-007 Port Mode, input, 1: 0 = direct decode of S; 1 = automatic channel scan.
REQ-008 Port S, input, SEL_W: channel select in direct mode; load value in scan mode.
REQ-009 Port Load, input, 1: in scan mode, load the scan index from S.
REQ-010 Port Mask, input, 2**SEL_W: per-channel scan eligibility (1 = eligible); ignored in direct mode.
REQ-011 Port O, output, 2**SEL_W: registered one-hot channel select, or all zeros.
REQ-012 Port Idx, output, SEL_W: registered current channel index.
REQ-013 Port Valid, output, 1: registered; 1 when O has exactly one bit set.
REQ-014 Port Wrap, output, 1: registered single-cycle pulse on scan wrap-around.

Function
REQ-015 All outputs SHALL be registered, with one-cycle latency from the inputs sampled at the edge to the outputs.
REQ-016 The FSM SHALL have states OFF, DIRECT and SCAN, evaluated each edge in priority order: Rst_n=0, then Enable=0 -> OFF, then Mode=0 -> DIRECT, else SCAN.
REQ-017 In OFF: O=0, Valid=0, Wrap=0; Idx and the dwell counter SHALL hold.
REQ-018 In DIRECT: Idx<=S, O<=1<<S, Valid<=1, Wrap<=0, dwell counter<=0; Mask SHALL be ignored.
REQ-019 In SCAN the dwell counter SHALL count 0..DWELL-1; at DWELL-1 it returns to 0 and Idx advances.
REQ-020 Advance SHALL select the next index after Idx, searching circularly, whose Mask bit is 1.
REQ-021 Wrap SHALL pulse for one cycle when an advance selects an index less than or equal to the current Idx; this includes a single eligible channel re-selecting itself.
REQ-022 If Mask is all zeros, Idx and the dwell counter SHALL hold, O=0, Valid=0 and Wrap=0.
REQ-023 In SCAN, O SHALL equal 1<<Idx when Mask[Idx]=1, else 0; Valid SHALL follow the same condition.
REQ-024 Load=1 in SCAN: Idx<=S and dwell<=0 regardless of Mask; Load SHALL take priority over a coincident advance, with Wrap=0 that cycle.
REQ-025 Load SHALL be ignored in OFF and DIRECT.
REQ-026 On entry to SCAN from DIRECT or OFF, scanning SHALL start from the held Idx with dwell=0.
REQ-027 A Mask change SHALL take effect at the next edge; mid-dwell, the current channel's output SHALL be gated per REQ-023 without forcing an advance.
REQ-028 With DWELL=1, Idx SHALL advance every SCAN cycle.
REQ-029 Idx arithmetic SHALL be modulo 2**SEL_W, and O SHALL never have more than one bit set.

Reset
REQ-030 While Rst_n=0 at an edge: O=0, Idx=0, Valid=0, Wrap=0, dwell=0, FSM=OFF; reset SHALL override all other inputs.
REQ-031 Reset asserted mid-scan SHALL clear all state at that edge; after release, behaviour SHALL resume per REQ-016 from Idx=0.

Verification (SEL_W=3, DWELL=4)
REQ-032 Rst_n=0 for 2 edges with Enable=1, Mode=0, S=5 -> O=0x00, Idx=0, Valid=0; first edge after release -> O=0x20, Idx=5, Valid=1.
REQ-033 Direct sweep S=0..7, one per cycle -> O=0x01..0x80 one cycle later; then Enable=0 -> O=0x00 and Valid=0 at the next edge, Idx held at 7.
REQ-034 Scan with Mask=0xFF from Idx=0 -> O=0x01 for 4 cycles, then 0x02 ... 0x80; the next advance gives O=0x01 with Wrap=1 for exactly one cycle.
REQ-035 Scan with Mask=0x24 -> O alternates 0x04/0x20 every 4 cycles, with Wrap=1 on each 0x20->0x04 transition; then Mask=0x00 -> O=0x00, Valid=0, Idx held.
REQ-036 Load=1 with S=6 on a dwell-expiry cycle -> Idx=6, O=0x40, Wrap=0, and O=0x40 held for 4 cycles.
REQ-037 Rst_n=0 during scan at Idx=5 -> next edge gives O=0x00, Idx=0, Wrap=0; after release with Mask=0xFF -> O=0x01 for 4 cycles.
